// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e    : controller FSM state (RUN, STALL)
//   REG_AW_DEF : default register address width
//   PCSEL_*    : PC mux select encodings
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam int unsigned REG_AW_DEF = 6;

    localparam logic PCSEL_INC = 1'b0;
    localparam logic PCSEL_BR  = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
//   master : pipeline datapath (drives ID/WB/branch status, receives enables)
//   slave  : pipe_hazard_ctrl (receives status, drives enables/flushes/counters)
// Inputs to the controller : id_valid, id_uses_rs, id_uses_rt, id_reg_wrt, id_rs, id_rt,
//                            id_rd, wb_reg_wrt, wb_rd, br_taken
// Outputs of the controller: pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush,
//                            pc_sel, stalled, stall_cnt
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 6,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_reg_wrt;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              wb_reg_wrt;
    logic [REG_AW-1:0] wb_rd;
    logic              br_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exwb_flush;
    logic              pc_sel;
    logic              stalled;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_uses_rs, id_uses_rt, id_reg_wrt, id_rs, id_rt, id_rd,
        output wb_reg_wrt, wb_rd, br_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush, pc_sel,
        input  stalled, stall_cnt
    );

    modport slave (
        input  id_valid, id_uses_rs, id_uses_rt, id_reg_wrt, id_rs, id_rt, id_rd,
        input  wb_reg_wrt, wb_rd, br_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush, pc_sel,
        output stalled, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
//   clk, rst_n          : clock, async active-low reset (clears all entries)
//   setEn/setIdx        : mark a register as having an in-flight writer
//   clrEn/clrIdx        : WB retire; also the bypass source for the lookups
//   squashEn/squashIdx  : drop the entry of a squashed EX-stage writer
//   lookupA/B, busyA/B  : combinational "still pending" queries for ID sources
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              setEn,
    input  logic [REG_AW-1:0] setIdx,
    input  logic              clrEn,
    input  logic [REG_AW-1:0] clrIdx,
    input  logic              squashEn,
    input  logic [REG_AW-1:0] squashIdx,
    input  logic [REG_AW-1:0] lookupA,
    input  logic [REG_AW-1:0] lookupB,
    output logic              busyA,
    output logic              busyB
);

    localparam int unsigned NumRegs = 2 ** REG_AW;

    logic [NumRegs-1:0] pendingQ;
    logic [NumRegs-1:0] pendingD;
    logic [NumRegs-1:0] setMask;
    logic [NumRegs-1:0] clrMask;
    logic [NumRegs-1:0] squashMask;
    logic               bypassA;
    logic               bypassB;

    always_comb begin
        setMask    = '0;
        clrMask    = '0;
        squashMask = '0;
        if (setEn)    setMask[setIdx]       = 1'b1;
        if (clrEn)    clrMask[clrIdx]       = 1'b1;
        if (squashEn) squashMask[squashIdx] = 1'b1;
        // Set is applied last: a newly issued writer is younger than the retiring one.
        pendingD = (pendingQ & ~clrMask & ~squashMask) | setMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingQ <= '0;
        end else begin
            pendingQ <= pendingD;
        end
    end

    // With a write-through register file the retiring value is already readable in ID.
    always_comb begin
        bypassA = WB_BYPASS && clrEn && (clrIdx == lookupA);
        bypassB = WB_BYPASS && clrEn && (clrIdx == lookupB);
        busyA   = pendingQ[lookupA] & ~bypassA;
        busyB   = pendingQ[lookupB] & ~bypassB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the IF/ID/EX/WB pipeline. Stalls PC and IF/ID while an ID
// source has an in-flight writer, and squashes/redirects when WB resolves a taken branch.
//   clk, rst_n : clock, async active-low reset
//   bus        : pipe_hazard_ctrl_if.slave
//                in : id_valid, id_uses_rs/rt, id_reg_wrt, id_rs/rt/rd, wb_reg_wrt, wb_rd,
//                     br_taken
//                out: pc_write, ifid_write, ifid_flush, idex_bubble, exwb_flush, pc_sel
//                     (combinational), stalled, stall_cnt (registered)
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    state_e            stateQ;
    logic              exVQ;
    logic [REG_AW-1:0] exRdQ;
    logic [CNT_W-1:0]  stallCntQ;

    logic busyRs;
    logic busyRt;
    logic hz;
    logic setEn;
    logic squashEn;

    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
    logic exwbFlush;
    logic pcSel;

    assign hz       = bus.id_valid & ((bus.id_uses_rs & busyRs) | (bus.id_uses_rt & busyRt));
    assign setEn    = ~bus.br_taken & ~hz & bus.id_valid & bus.id_reg_wrt;
    // The EX-stage instruction is on the wrong path when WB redirects.
    assign squashEn = bus.br_taken & exVQ;

    hazard_scoreboard #(
        .REG_AW    (REG_AW),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .setEn     (setEn),
        .setIdx    (bus.id_rd),
        .clrEn     (bus.wb_reg_wrt),
        .clrIdx    (bus.wb_rd),
        .squashEn  (squashEn),
        .squashIdx (exRdQ),
        .lookupA   (bus.id_rs),
        .lookupB   (bus.id_rt),
        .busyA     (busyRs),
        .busyB     (busyRt)
    );

    // Reset forces the free-running defaults so the pipeline idles cleanly in reset.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        exwbFlush  = 1'b0;
        pcSel      = PCSEL_INC;
        if (!rst_n) begin
            pcWrite = 1'b1;
        end else if (bus.br_taken) begin
            pcSel      = PCSEL_BR;
            pcWrite    = 1'b1;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            exwbFlush  = 1'b1;
        end else if (hz) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= RUN;
            exVQ      <= 1'b0;
            exRdQ     <= '0;
            stallCntQ <= '0;
        end else if (bus.br_taken) begin
            stateQ <= RUN;
            exVQ   <= 1'b0;
        end else if (hz) begin
            stateQ <= STALL;
            exVQ   <= 1'b0;
            if (stallCntQ != {CNT_W{1'b1}}) stallCntQ <= stallCntQ + 1'b1;
        end else begin
            stateQ <= RUN;
            exVQ   <= bus.id_valid & bus.id_reg_wrt;
            exRdQ  <= bus.id_rd;
        end
    end

    assign bus.pc_write    = pcWrite;
    assign bus.ifid_write  = ifidWrite;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_bubble = idexBubble;
    assign bus.exwb_flush  = exwbFlush;
    assign bus.pc_sel      = pcSel;
    assign bus.stalled     = (stateQ == STALL);
    assign bus.stall_cnt   = stallCntQ;

endmodule
